// File: rtl/multi_rate_divider_pkg.sv
`default_nettype none
// ============================================================================
// multi_rate_divider_pkg : shared constants and (D,H) clamp helpers
// Rev 1.0
// ============================================================================
package multi_rate_divider_pkg;

  localparam int DIV_MIN     = 2;
  localparam int N_CH_DEF    = 3;
  localparam int CNT_W_DEF   = 16;
  localparam int DIV_RST_DEF = 2500;

  // Helpers work on 32-bit values; callers zero-extend and truncate back.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
  endfunction

  function automatic logic [31:0] clamp_high(input logic [31:0] d,
                                             input logic [31:0] h);
    logic [31:0] dc;
    dc = clamp_div(d);
    return (h > dc) ? dc : h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/divider_channel.sv
`default_nettype none
// ============================================================================
// divider_channel : one counter with active/shadow (D,H), pending flag, output
// Rev 1.0
// ============================================================================
module divider_channel
  import multi_rate_divider_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             resync,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  input  logic [CNT_W-1:0] wr_high_i,
  output logic             pending_o,
  output logic             clk_out_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] c_DIV_RST  = CNT_W'(DIV_RST);
  localparam logic [CNT_W-1:0] c_HIGH_RST = CNT_W'(DIV_RST / 2);
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] div_q,   div_d;
  logic [CNT_W-1:0] high_q,  high_d;
  logic [CNT_W-1:0] sdiv_q,  sdiv_d;
  logic [CNT_W-1:0] shigh_q, shigh_d;
  logic             pend_q,  pend_d;
  logic             clk_q,   clk_d;
  logic             w_wrap;

  assign w_wrap    = (cnt_q == (div_q - c_ONE));
  assign tick_o    = en & w_wrap & ~rst;
  assign pending_o = pend_q;
  assign clk_out_o = clk_q;

  always_comb begin
    cnt_d   = cnt_q;
    div_d   = div_q;
    high_d  = high_q;
    sdiv_d  = sdiv_q;
    shigh_d = shigh_q;
    pend_d  = pend_q;

    if (resync || (en && w_wrap)) begin
      cnt_d = '0;
      if (pend_q) begin
        div_d  = sdiv_q;
        high_d = shigh_q;
      end
      pend_d = 1'b0;
    end else if (en) begin
      cnt_d = cnt_q + c_ONE;
    end

    // A write on a wrap/resync edge lands in the shadow only, so it waits a full period.
    if (wr_i) begin
      sdiv_d  = CNT_W'(clamp_div(32'(wr_div_i)));
      shigh_d = CNT_W'(clamp_high(32'(wr_div_i), 32'(wr_high_i)));
      pend_d  = 1'b1;
    end

    // Output is computed from the next-state values so it moves with the counter.
    clk_d = (cnt_d >= (div_d - high_d));
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q   <= '0;
      div_q   <= c_DIV_RST;
      high_q  <= c_HIGH_RST;
      sdiv_q  <= c_DIV_RST;
      shigh_q <= c_HIGH_RST;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      high_q  <= high_d;
      sdiv_q  <= sdiv_d;
      shigh_q <= shigh_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/multi_rate_divider.sv
`default_nettype none
// ============================================================================
// multi_rate_divider : N_CH programmable clock dividers with shared config port
// Rev 1.0
// ============================================================================
module multi_rate_divider
  import multi_rate_divider_pkg::*;
#(
  parameter  int N_CH    = N_CH_DEF,
  parameter  int CNT_W   = CNT_W_DEF,
  parameter  int DIV_RST = DIV_RST_DEF,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             resync,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick
);

  logic [N_CH-1:0] w_pend;
  logic [N_CH-1:0] w_wr;

  // Out-of-range channel indices stay ready so their writes are accepted and dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~w_pend[i];
      end
    end
    if (rst) begin
      cfg_ready = 1'b1;
    end
  end

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign w_wr[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));

      divider_channel #(
        .CNT_W   (CNT_W),
        .DIV_RST (DIV_RST)
      ) u_ch (
        .clk_in    (clk_in),
        .rst       (rst),
        .en        (en),
        .resync    (resync),
        .wr_i      (w_wr[i]),
        .wr_div_i  (cfg_div),
        .wr_high_i (cfg_high),
        .pending_o (w_pend[i]),
        .clk_out_o (clk_out[i]),
        .tick_o    (tick[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/multi_rate_divider.md
MULTI_RATE_DIVIDER -- requirements
Module: multi_rate_divider

Interface
REQ-001 Parameter N_CH, default 3: number of independent divider channels (1..8).
REQ-002 Parameter CNT_W, default 16: counter, divisor and high-time width.
REQ-003 Parameter DIV_RST, default 2500: per-channel divisor loaded at reset (2 <= DIV_RST < 2^CNT_W).
REQ-004 Ports SHALL be, clock and reset first:
- clk_in  in  1: single clock; all logic on rising edge.
- rst  in  1: synchronous, active-high reset.
- en  in  1: global count enable.
- resync  in  1: one-cycle pulse restarting all channels in phase.
- cfg_valid  in  1: configuration request.
- cfg_ready  out  1: configuration accepted when high with cfg_valid.
- cfg_ch  in  max(1,$clog2(N_CH)): target channel.
- cfg_div  in  CNT_W: requested period D, in clk_in cycles.
- cfg_high  in  CNT_W: requested high time H, in clk_in cycles.
- clk_out  out  N_CH: divided clock per channel, registered.
- tick  out  N_CH: one-cycle pulse on the last cycle of each period.

Function
REQ-005 Each channel SHALL hold an active (D,H) pair and a counter c cycling 0..D-1, advancing by 1 per cycle while en=1.
REQ-006 clk_out[i] SHALL be 1 exactly while c is in [D-H, D-1] and 0 otherwise; it is updated on the same edge as c, giving zero-cycle skew against c.
REQ-007 With the defaults (D=2500, H=1250), clk_out SHALL be low for 1250 cycles, then high for 1250.
REQ-008 tick[i] SHALL be 1 in the cycle where c=D-1 and en=1, and 0 otherwise.
REQ-009 When en=0: counters and clk_out SHALL hold, tick SHALL be 0, and pending configurations SHALL remain pending.
REQ-010 Handshake: cfg_ready = NOT pending[cfg_ch]; a transfer occurs when cfg_valid=1 and cfg_ready=1.
REQ-011 On transfer, the channel's shadow (D,H) SHALL be written and pending set; cfg_ready for that channel SHALL drop the next cycle.
REQ-012 A pending configuration SHALL be applied at the wrap edge (c=D-1, en=1): c goes to 0 under the new (D,H), and pending clears. Output periods are never truncated or glitched.
REQ-013 Clamping SHALL be applied at write: D<2 becomes 2; H>D becomes D (clk_out constant high); H=0 gives clk_out constant low.
REQ-014 resync=1 SHALL set every counter to 0, apply all pending configurations, clear pending, and drive clk_out to its c=0 value. This occurs regardless of en.
REQ-015 A transfer in the same cycle as resync or a wrap SHALL become pending and apply at the following wrap, not immediately.
REQ-016 When resync and a wrap coincide, the resync behaviour governs.
REQ-017 A transfer to a channel index >= N_CH SHALL be accepted and discarded.

Reset
REQ-018 While rst=1, every channel SHALL take c=0, D=DIV_RST, H=DIV_RST/2, pending=0; clk_out and tick SHALL be 0 and cfg_ready SHALL be 1.
REQ-019 rst SHALL override en, resync and any configuration transfer in the same cycle.
REQ-020 rst asserted mid-period SHALL discard active and pending configurations.

Structure
REQ-021 A shared package SHALL hold DIV_MIN=2, the defaults for CNT_W, N_CH and DIV_RST, and the clamp function for (D,H).
REQ-022 One sub-module, divider_channel, SHALL implement the counter, shadow, pending flag and output for one channel; it is instantiated N_CH times via generate.

Verification
REQ-023 Reset, en=1, defaults -> clk_out[0] low for 1250 cycles, then high for 1250; tick[0] pulses every 2500 cycles.
REQ-024 Write ch1 D=10, H=3 mid-period -> old period completes; then clk_out[1] is 7 low, 3 high; cfg_ready stays low until the wrap.
REQ-025 Write ch2 D=1, H=5 -> clamped to D=2, H=2, so clk_out[2] is constant 1; write H=0 -> clk_out[2] constant 0.
REQ-026 Pending ch0 D=8, then resync pulse -> all counters restart at 0 in the same cycle; ch0 period 8 takes effect immediately.
REQ-027 en=0 for 17 cycles mid-period -> counters, clk_out and pending frozen; tick=0; the period resumes with no lost or extra cycles.
REQ-028 rst pulse during a pending write -> all channels revert to 2500/1250, and cfg_ready=1 on the next cycle.
